// File: rtl/stack_frame_ctrl_if.sv
// Command/response handshake bundle for stack_frame_ctrl.
// master drives commands and accepts responses; slave is the controller.
interface stack_frame_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd;
    logic [WIDTH-1:0] cmd_data;
    logic [DEPTH:0]   cmd_arg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_status;

    modport master (
        output cmd_valid, cmd, cmd_data, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd, cmd_data, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/stack_frame_ctrl.sv
// Frame-aware front end for an external stack: translates commands into single-cycle
// stack ops, keeps a small record of saved frame bases, and returns fixed-latency responses.
module stack_frame_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 7,
    parameter int FRAMES = 4
) (
    input  logic                clk,
    input  logic                reset,
    stack_frame_ctrl_if.slave   bus,
    output logic [2:0]          stk_op,
    output logic [WIDTH-1:0]    stk_data,
    output logic [DEPTH:0]      stk_offset,
    output logic [DEPTH:0]      stk_underflow_limit,
    output logic [DEPTH:0]      stk_upper_limit,
    output logic [DEPTH:0]      stk_lower_limit,
    input  logic [DEPTH:0]      stk_index,
    input  logic [WIDTH-1:0]    stk_out,
    input  logic [2:0]          stk_status
);
    localparam int AW = DEPTH + 1;
    localparam int CW = $clog2(FRAMES + 1);
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic [2:0] C_PUSH = 3'd1, C_POP = 3'd2, C_REPLACE = 3'd3, C_ENTER = 3'd4,
                           C_LEAVE = 3'd5, C_LGET = 3'd6, C_LSET = 3'd7;
    localparam logic [2:0] OP_NONE = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_REPLACE = 3'd3,
                           OP_IDX_RST = 3'd4, OP_IDX_RST_PUSH = 3'd5,
                           OP_UF_GET = 3'd6, OP_UF_SET = 3'd7;
    localparam logic [2:0] ST_NONE = 3'd0, ST_UNDERFLOW = 3'd3, ST_OVERFLOW = 3'd4,
                           ST_BAD_OFFSET = 3'd5, ST_FRAME_ERR = 3'd6;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_status_q, rsp_status_d;
    logic [2:0]       stk_op_q, stk_op_d;
    logic [WIDTH-1:0] stk_data_q, stk_data_d;
    logic [AW-1:0]    stk_offset_q, stk_offset_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [AW-1:0]    arg_q, arg_d;
    logic [WIDTH-1:0] held_top_q, held_top_d;
    logic [AW-1:0]    frame_base_q, frame_base_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic [AW-1:0]    rec_q [FRAMES];
    logic [AW-1:0]    rec_d [FRAMES];

    logic [AW-1:0]    avail;
    logic [CW-1:0]    fcnt_m1;
    logic             rec_full, rec_empty, stk_err;

    // stk_index never drops below frame_base, so this difference cannot wrap
    assign avail     = stk_index - frame_base_q;
    assign fcnt_m1   = fcnt_q - 1'b1;
    assign rec_full  = (fcnt_q == CW'(FRAMES));
    assign rec_empty = (fcnt_q == '0);
    assign stk_err   = stk_status inside {ST_UNDERFLOW, ST_OVERFLOW, ST_BAD_OFFSET};

    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        stk_op_d     = OP_NONE;
        stk_data_d   = stk_data_q;
        stk_offset_d = stk_offset_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        held_top_d   = held_top_q;
        frame_base_d = frame_base_q;
        fcnt_d       = fcnt_q;
        rec_d        = rec_q;

        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                cmd_d        = bus.cmd;
                arg_d        = bus.cmd_arg;
                held_top_d   = stk_out;
                stk_data_d   = bus.cmd_data;
                stk_offset_d = '0;
                state_d      = ISSUE;
                case (bus.cmd)
                    C_PUSH:    stk_op_d = OP_PUSH;
                    C_REPLACE: stk_op_d = OP_REPLACE;
                    C_POP: begin
                        stk_op_d   = OP_POP;
                        stk_data_d = WIDTH'(bus.cmd_arg);
                    end
                    C_LEAVE: if (!rec_empty) begin
                        // nonzero arg carries the current top across the frame collapse
                        stk_op_d     = (bus.cmd_arg == '0) ? OP_IDX_RST : OP_IDX_RST_PUSH;
                        stk_offset_d = frame_base_q;
                        stk_data_d   = stk_out;
                    end
                    C_LGET: begin
                        stk_op_d     = OP_UF_GET;
                        stk_offset_d = bus.cmd_arg;
                    end
                    C_LSET: begin
                        stk_op_d     = OP_UF_SET;
                        stk_offset_d = bus.cmd_arg;
                    end
                    default: ;
                endcase
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_status_d = stk_status;
                rsp_data_d   = stk_out;
                case (cmd_q)
                    C_POP: rsp_data_d = held_top_q;
                    C_ENTER: begin
                        rsp_data_d = held_top_q;
                        if (rec_full || arg_q > avail) begin
                            rsp_status_d = ST_FRAME_ERR;
                        end else begin
                            rsp_status_d              = ST_NONE;
                            rec_d[fcnt_q[FW-1:0]]     = frame_base_q;
                            fcnt_d                    = fcnt_q + 1'b1;
                            frame_base_d              = stk_index - arg_q;
                        end
                    end
                    C_LEAVE: begin
                        rsp_data_d = held_top_q;
                        if (rec_empty) begin
                            rsp_status_d = ST_FRAME_ERR;
                        end else if (!stk_err) begin
                            frame_base_d = rec_q[fcnt_m1[FW-1:0]];
                            fcnt_d       = fcnt_m1;
                        end
                    end
                    default: ;
                endcase
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            stk_op_q     <= OP_NONE;
            stk_data_q   <= '0;
            stk_offset_q <= '0;
            cmd_q        <= '0;
            arg_q        <= '0;
            held_top_q   <= '0;
            frame_base_q <= '0;
            fcnt_q       <= '0;
            for (int i = 0; i < FRAMES; i++) rec_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            stk_op_q     <= stk_op_d;
            stk_data_q   <= stk_data_d;
            stk_offset_q <= stk_offset_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            held_top_q   <= held_top_d;
            frame_base_q <= frame_base_d;
            fcnt_q       <= fcnt_d;
            rec_q        <= rec_d;
        end
    end

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.rsp_status      = rsp_status_q;
    assign stk_op              = stk_op_q;
    assign stk_data            = stk_data_q;
    assign stk_offset          = stk_offset_q;
    assign stk_underflow_limit = frame_base_q;
    assign stk_lower_limit     = frame_base_q;
    assign stk_upper_limit     = stk_index;
endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Directed bench for stack_frame_ctrl: a behavioural stack answers the stack ops,
// a vector table drives commands, and hand sequences cover back-pressure and mid-command reset.
module tb_stack_frame_ctrl;
    localparam int WIDTH = 8, DEPTH = 7, FRAMES = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    stack_frame_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    logic [2:0] stk_op;
    logic [7:0] stk_data, stk_offset, stk_underflow_limit, stk_upper_limit, stk_lower_limit;
    logic [7:0] s_idx = 8'd0, s_out = 8'd0;
    logic [2:0] s_status = 3'd0;
    logic [7:0] mem [0:255] = '{default: 8'd0};

    stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .stk_op              (stk_op),
        .stk_data            (stk_data),
        .stk_offset          (stk_offset),
        .stk_underflow_limit (stk_underflow_limit),
        .stk_upper_limit     (stk_upper_limit),
        .stk_lower_limit     (stk_lower_limit),
        .stk_index           (s_idx),
        .stk_out             (s_out),
        .stk_status          (s_status)
    );

    always #5 clk = ~clk;

    // Behavioural stack: top-relative offsets, bounded below by the lower limit
    always @(posedge clk) begin : stack_model
        logic [7:0] ni, avail, top, rd;
        logic [2:0] st;
        logic       rd_ok;
        ni = s_idx; st = 3'd0; avail = s_idx - stk_lower_limit; rd = 8'd0; rd_ok = 1'b0;
        case (stk_op)
            3'd0: if (s_idx == 8'd0) st = 3'd1;
            3'd1: if (s_idx == 8'hFF) st = 3'd4;
                  else begin mem[s_idx] <= stk_data; ni = s_idx + 8'd1; end
            3'd2: if ({1'b0, stk_data} + 9'd1 > {1'b0, avail}) st = 3'd3;
                  else ni = s_idx - stk_data - 8'd1;
            3'd3: if (avail == 8'd0) st = 3'd3; else mem[s_idx - 8'd1] <= stk_data;
            3'd4: ni = stk_offset;
            3'd5: begin mem[stk_offset] <= stk_data; ni = stk_offset + 8'd1; end
            3'd6: if (stk_offset >= avail) st = 3'd5;
                  else begin rd = mem[s_idx - 8'd1 - stk_offset]; rd_ok = 1'b1; end
            default: if (stk_offset >= avail) st = 3'd5;
                     else mem[s_idx - 8'd1 - stk_offset] <= stk_data;
        endcase
        top = (ni == 8'd0) ? 8'd0 : mem[ni - 8'd1];
        if (st == 3'd0 && (stk_op inside {3'd1, 3'd3, 3'd5} || (stk_op == 3'd7 && stk_offset == 8'd0)))
            top = stk_data;
        if (rd_ok) top = rd;
        s_idx <= ni; s_status <= st; s_out <= top;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0] c;
        logic [7:0] d, a, xd;
        logic [2:0] xs;
        bit         cd, nop;
        logic [7:0] xi, xb;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic [2:0] c, input logic [7:0] d, a, xd, input logic [2:0] xs,
                       input bit cd, nop, input logic [7:0] xi, xb);
        vec_t v;
        v.c = c; v.d = d; v.a = a; v.xd = xd; v.xs = xs; v.cd = cd; v.nop = nop; v.xi = xi; v.xb = xb;
        tv.push_back(v);
    endtask

    // One full transaction; 'now' skips the initial negedge so the command lands on the next edge
    task automatic do_cmd(input string tag, input bit now, input logic [2:0] c, input logic [7:0] d, a,
                          output logic [7:0] rd, output logic [2:0] rs, output int lat, output bit op_seen);
        int w;
        if (!now) @(negedge clk);
        w = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd = c; bus.cmd_data = d; bus.cmd_arg = a;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        lat = 0; op_seen = 1'b0;
        while (lat < 20) begin
            @(negedge clk); lat++;
            if (stk_op != 3'd0) op_seen = 1'b1;
            if (bus.rsp_valid) break;
        end
        rd = bus.rsp_data; rs = bus.rsp_status;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] rd, hd;
        logic [2:0] rs, hs;
        int lat;
        bit op_seen, stable;

        bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.cmd_data = 8'd0; bus.cmd_arg = 8'd0; bus.rsp_ready = 1'b0;

        #12;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_status", bus.rsp_status, 0);
        chk("rst_stk_op", stk_op, 0);
        chk("rst_stk_data", stk_data, 0);
        chk("rst_stk_offset", stk_offset, 0);
        chk("rst_lower", stk_lower_limit, 0);
        chk("rst_underflow", stk_underflow_limit, 0);
        @(negedge clk); reset = 1'b0;

        //   cmd  data   arg   exp_d  st  cd nop idx base
        add(3'd1, 8'h11, 8'd0, 8'h11, 3'd0, 1, 0, 8'd1, 8'd0);
        add(3'd1, 8'h22, 8'd0, 8'h22, 3'd0, 1, 0, 8'd2, 8'd0);
        add(3'd2, 8'h00, 8'd0, 8'h22, 3'd0, 1, 0, 8'd1, 8'd0);
        add(3'd0, 8'h00, 8'd0, 8'h11, 3'd0, 1, 1, 8'd1, 8'd0);
        add(3'd1, 8'hA1, 8'd0, 8'hA1, 3'd0, 1, 0, 8'd2, 8'd0);
        add(3'd1, 8'hA2, 8'd0, 8'hA2, 3'd0, 1, 0, 8'd3, 8'd0);
        add(3'd1, 8'hA3, 8'd0, 8'hA3, 3'd0, 1, 0, 8'd4, 8'd0);
        add(3'd4, 8'h00, 8'd2, 8'hA3, 3'd0, 1, 1, 8'd4, 8'd2);
        add(3'd6, 8'h00, 8'd1, 8'hA2, 3'd0, 1, 0, 8'd4, 8'd2);
        add(3'd6, 8'h00, 8'd2, 8'h00, 3'd5, 0, 0, 8'd4, 8'd2);
        add(3'd7, 8'h77, 8'd0, 8'h77, 3'd0, 1, 0, 8'd4, 8'd2);
        add(3'd2, 8'h00, 8'd1, 8'h77, 3'd0, 1, 0, 8'd2, 8'd2);
        add(3'd2, 8'h00, 8'd0, 8'hA1, 3'd3, 1, 0, 8'd2, 8'd2);
        add(3'd3, 8'h99, 8'd0, 8'h00, 3'd3, 0, 0, 8'd2, 8'd2);
        add(3'd5, 8'h00, 8'd0, 8'hA1, 3'd0, 1, 0, 8'd2, 8'd0);
        add(3'd4, 8'h00, 8'd3, 8'h00, 3'd6, 0, 1, 8'd2, 8'd0);
        add(3'd4, 8'h00, 8'd2, 8'hA1, 3'd0, 1, 1, 8'd2, 8'd0);
        add(3'd5, 8'h00, 8'd0, 8'hA1, 3'd0, 1, 0, 8'd0, 8'd0);
        add(3'd5, 8'h00, 8'd0, 8'h00, 3'd6, 0, 1, 8'd0, 8'd0);
        add(3'd1, 8'h10, 8'd0, 8'h10, 3'd0, 1, 0, 8'd1, 8'd0);
        add(3'd1, 8'h20, 8'd0, 8'h20, 3'd0, 1, 0, 8'd2, 8'd0);
        add(3'd4, 8'h00, 8'd0, 8'h20, 3'd0, 1, 1, 8'd2, 8'd2);
        add(3'd1, 8'h5A, 8'd0, 8'h5A, 3'd0, 1, 0, 8'd3, 8'd2);
        add(3'd5, 8'h00, 8'd1, 8'h5A, 3'd0, 1, 0, 8'd3, 8'd0);
        add(3'd0, 8'h00, 8'd0, 8'h5A, 3'd0, 1, 1, 8'd3, 8'd0);
        add(3'd4, 8'h00, 8'd3, 8'h5A, 3'd0, 1, 1, 8'd3, 8'd0);
        add(3'd4, 8'h00, 8'd2, 8'h5A, 3'd0, 1, 1, 8'd3, 8'd1);
        add(3'd4, 8'h00, 8'd1, 8'h5A, 3'd0, 1, 1, 8'd3, 8'd2);
        add(3'd4, 8'h00, 8'd0, 8'h5A, 3'd0, 1, 1, 8'd3, 8'd3);
        add(3'd4, 8'h00, 8'd0, 8'h00, 3'd6, 0, 1, 8'd3, 8'd3);
        add(3'd5, 8'h00, 8'd0, 8'h5A, 3'd0, 1, 0, 8'd3, 8'd2);
        add(3'd5, 8'h00, 8'd0, 8'h5A, 3'd0, 1, 0, 8'd2, 8'd1);
        add(3'd5, 8'h00, 8'd0, 8'h20, 3'd0, 1, 0, 8'd1, 8'd0);
        add(3'd5, 8'h00, 8'd0, 8'h10, 3'd0, 1, 0, 8'd0, 8'd0);
        add(3'd0, 8'h00, 8'd0, 8'h00, 3'd1, 1, 1, 8'd0, 8'd0);

        foreach (tv[i]) begin
            string t;
            t = $sformatf("r%0d", i);
            do_cmd(t, 1'b0, tv[i].c, tv[i].d, tv[i].a, rd, rs, lat, op_seen);
            chk({t, "_lat"}, lat, 3);
            chk({t, "_status"}, rs, tv[i].xs);
            if (tv[i].cd) chk({t, "_data"}, rd, tv[i].xd);
            if (tv[i].nop) chk({t, "_no_op"}, op_seen, 0);
            chk({t, "_idx"}, s_idx, tv[i].xi);
            chk({t, "_base"}, stk_lower_limit, tv[i].xb);
            chk({t, "_upper"}, stk_upper_limit, tv[i].xi);
        end

        // back-pressure: response held while rsp_ready low; stray cmd_valid/rsp_ready ignored
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = 3'd1; bus.cmd_data = 8'h3C; bus.cmd_arg = 8'd0;
        @(posedge clk); #1 bus.cmd = 3'd2; bus.rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk); bus.rsp_ready = 1'b0;
        lat = 2;
        while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("hold_lat", lat, 3);
        hd = bus.rsp_data; hs = bus.rsp_status;
        chk("hold_data", hd, 8'h3C);
        chk("hold_status", hs, 0);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== hd || bus.rsp_status !== hs || bus.cmd_ready) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        chk("hold_released", bus.rsp_valid, 0);
        chk("hold_idx", s_idx, 8'd1);

        // reset in the ISSUE cycle of a PUSH with an open frame
        do_cmd("pre_rst_enter", 1'b0, 3'd4, 8'h00, 8'd0, rd, rs, lat, op_seen);
        chk("pre_rst_base", stk_lower_limit, 8'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = 3'd1; bus.cmd_data = 8'h4D; bus.cmd_arg = 8'd0;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("issue_op", stk_op, 3'd1);
        reset = 1'b1; #1;
        chk("mid_rst_op", stk_op, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_base", stk_lower_limit, 0);
        @(negedge clk); @(negedge clk);
        chk("mid_rst_idx", s_idx, 8'd1);
        reset = 1'b0;
        do_cmd("post_rst", 1'b1, 3'd1, 8'h4D, 8'd0, rd, rs, lat, op_seen);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 8'h4D);
        chk("post_rst_idx", s_idx, 8'd2);
        do_cmd("post_rst_leave", 1'b0, 3'd5, 8'h00, 8'd0, rd, rs, lat, op_seen);
        chk("post_rst_leave_st", rs, 3'd6);
        chk("post_rst_leave_noop", op_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
